// File: rtl/mem_bus_arbiter.sv
// Shares the single external memory port between the fetch and load/store stages.
// Load/store wins ties; fetch results are discarded on flush; stuck cycles end on timeout.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_sel_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ack_o,
  input  logic        flush_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_sel_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        stallreq_if_o,
  output logic        stallreq_mem_o,
  output logic        err_o
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               drop_q, drop_d;
  logic               bus_req_q, bus_req_d;
  logic               bus_we_q, bus_we_d;
  logic [DATA_W-1:0]  bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]  bus_wdata_q, bus_wdata_d;
  logic [SEL_W-1:0]   bus_sel_q, bus_sel_d;

  logic busy_c;
  logic timeout_c;
  logic done_c;

  // A real acknowledge in the timeout cycle wins over the timeout.
  assign busy_c    = (state_q != IDLE);
  assign timeout_c = busy_c && !bus_ack_i && (cnt_q == CNT_W'(TIMEOUT));
  assign done_c    = busy_c && (bus_ack_i || timeout_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      drop_q      <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_sel_q   <= bus_sel_d;
    end
  end

  // Arbitration, bus command capture and completion handling.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drop_d      = drop_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_sel_d   = bus_sel_q;

    case (state_q)
      IDLE: begin
        if (mem_req_i) begin
          state_d     = BUSY_MEM;
          cnt_d       = '0;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we_i;
          bus_addr_d  = mem_addr_i;
          bus_wdata_d = mem_wdata_i;
          bus_sel_d   = mem_sel_i;
        end else if (if_req_i) begin
          state_d     = BUSY_IF;
          cnt_d       = '0;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr_i;
          bus_wdata_d = '0;
          bus_sel_d   = '1;
        end
      end
      BUSY_IF, BUSY_MEM: begin
        if (done_c) begin
          state_d     = IDLE;
          cnt_d       = '0;
          drop_d      = 1'b0;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = '0;
          bus_wdata_d = '0;
          bus_sel_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if ((state_q == BUSY_IF) && flush_i) begin
            drop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Requester responses are combinational from the slave acknowledge.
  always_comb begin
    if_ack_o    = 1'b0;
    mem_ack_o   = 1'b0;
    if_rdata_o  = '0;
    mem_rdata_o = '0;
    err_o       = 1'b0;
    if (!rst) begin
      err_o     = timeout_c;
      if_ack_o  = (state_q == BUSY_IF) && done_c && !drop_q && !flush_i;
      mem_ack_o = (state_q == BUSY_MEM) && done_c;
      if (if_ack_o && bus_ack_i) begin
        if_rdata_o = bus_rdata_i;
      end
      if (mem_ack_o && bus_ack_i) begin
        mem_rdata_o = bus_rdata_i;
      end
    end
  end

  assign stallreq_if_o  = if_req_i & ~if_ack_o;
  assign stallreq_mem_o = mem_req_i & ~mem_ack_o;

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_sel_o   = bus_sel_q;

endmodule
